// File: rtl/brisc_pkg.sv
// Shared BRISC memory-system widths and the cache-to-memory operation encoding.
package brisc_pkg;

    localparam int unsigned ADDRESS_BITS   = 32;
    localparam int unsigned CACHE_LINE_LEN = 128;
    localparam int unsigned OFFSET_BITS    = $clog2(CACHE_LINE_LEN / 8);
    localparam int unsigned TAG_BITS       = ADDRESS_BITS - OFFSET_BITS;

    typedef enum logic {
        STORE = 1'b0,
        LOAD  = 1'b1
    } mem_op_e;

endpackage

// File: rtl/main_memory.sv
// Line-wide backing store: synchronous write, combinational read.
module main_memory #(
  parameter int unsigned MEM_LINES     = 1024,
  parameter int unsigned LINE_LEN      = 128,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_LINES)-1:0] addr,
  input  logic [LINE_LEN-1:0]          wdata,
  output logic [LINE_LEN-1:0]          rdata
);

  logic [LINE_LEN-1:0] mem [MEM_LINES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction and data caches in front of a fixed-latency backing store.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int unsigned MEM_LATENCY   = 5,
    parameter int unsigned MEM_LINES     = 1024,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ic_req,
    input  logic                      dc_req,
    input  logic                      ic_mem_instr,
    input  logic                      dc_mem_instr,
    input  logic [TAG_BITS-1:0]       ic_addr,
    input  logic [TAG_BITS-1:0]       dc_addr,
    input  logic [CACHE_LINE_LEN-1:0] ic_wdata,
    input  logic [CACHE_LINE_LEN-1:0] dc_wdata,
    output logic                      ic_grant,
    output logic                      dc_grant,
    output logic                      ic_resp,
    output logic                      dc_resp,
    output logic [CACHE_LINE_LEN-1:0] ic_fill,
    output logic [CACHE_LINE_LEN-1:0] dc_fill
);

    localparam int unsigned IDX_W = $clog2(MEM_LINES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e                    state, state_next;
    logic [3:0]                cnt;
    mem_op_e                   op_q;
    logic [IDX_W-1:0]          addr_q;
    logic [CACHE_LINE_LEN-1:0] wdata_q;
    logic                      sel_dc_q;
    logic                      last_dc;

    logic                      pick_dc;
    logic                      any_req;
    logic [TAG_BITS-1:0]       win_addr;
    logic [CACHE_LINE_LEN-1:0] mem_rdata;
    logic [CACHE_LINE_LEN-1:0] line;
    logic                      mem_we;
    logic                      unused_addr_bits;

    // Upper tag bits alias onto the same line by design.
    assign unused_addr_bits = ^{ic_addr, dc_addr};

    assign any_req  = ic_req | dc_req;
    assign pick_dc  = dc_req & (~ic_req | ~last_dc);
    assign win_addr = pick_dc ? dc_addr : ic_addr;
    assign line     = (op_q == LOAD) ? mem_rdata : wdata_q;
    // Gating with rst_n keeps a reset during RESP from committing the store.
    assign mem_we   = (state == RESP) && (op_q == STORE) && rst_n;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= STORE;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_dc_q <= 1'b0;
            last_dc  <= 1'b1;
            ic_grant <= 1'b0;
            dc_grant <= 1'b0;
            ic_resp  <= 1'b0;
            dc_resp  <= 1'b0;
            ic_fill  <= '0;
            dc_fill  <= '0;
        end else begin
            state    <= state_next;
            ic_grant <= 1'b0;
            dc_grant <= 1'b0;
            ic_resp  <= 1'b0;
            dc_resp  <= 1'b0;
            ic_fill  <= '0;
            dc_fill  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel_dc_q <= pick_dc;
                        last_dc  <= pick_dc;
                        op_q     <= mem_op_e'(pick_dc ? dc_mem_instr : ic_mem_instr);
                        addr_q   <= win_addr[IDX_W-1:0];
                        wdata_q  <= pick_dc ? dc_wdata : ic_wdata;
                        cnt      <= 4'(MEM_LATENCY - 1);
                        ic_grant <= ~pick_dc;
                        dc_grant <= pick_dc;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else if (sel_dc_q) begin
                        dc_resp <= 1'b1;
                        dc_fill <= line;
                    end else begin
                        ic_resp <= 1'b1;
                        ic_fill <= line;
                    end
                end
                default: ;
            endcase
        end
    end

    main_memory #(
        .MEM_LINES    (MEM_LINES),
        .LINE_LEN     (CACHE_LINE_LEN),
        .MEM_INIT_FILE(MEM_INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-latency instance plus a MEM_LATENCY=2 instance.
module tb_mem_arbiter;
    import brisc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                      ic_req, dc_req, ic_op, dc_op;
    logic [TAG_BITS-1:0]       ic_addr, dc_addr;
    logic [CACHE_LINE_LEN-1:0] ic_wdata, dc_wdata;
    logic                      ic_grant, dc_grant, ic_resp, dc_resp;
    logic [CACHE_LINE_LEN-1:0] ic_fill, dc_fill;

    logic                      f_ic_req, f_dc_req, f_ic_op, f_dc_op;
    logic [TAG_BITS-1:0]       f_ic_addr, f_dc_addr;
    logic [CACHE_LINE_LEN-1:0] f_ic_wdata, f_dc_wdata;
    logic                      f_ic_grant, f_dc_grant, f_ic_resp, f_dc_resp;
    logic [CACHE_LINE_LEN-1:0] f_ic_fill, f_dc_fill;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [127:0] PAT_A = {4{32'hA5A5_0001}};
    localparam logic [127:0] PAT_B = {4{32'hB00B_1234}};
    localparam logic [127:0] PAT_C = {4{32'hC0DE_5678}};
    localparam logic [127:0] PAT_D = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] PAT_E = {4{32'hE1E1_9ABC}};
    localparam logic [127:0] PAT_F = {4{32'hF00D_4321}};

    mem_arbiter #(.MEM_LATENCY(5), .MEM_LINES(1024)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .dc_req(dc_req),
        .ic_mem_instr(ic_op), .dc_mem_instr(dc_op),
        .ic_addr(ic_addr), .dc_addr(dc_addr),
        .ic_wdata(ic_wdata), .dc_wdata(dc_wdata),
        .ic_grant(ic_grant), .dc_grant(dc_grant),
        .ic_resp(ic_resp), .dc_resp(dc_resp),
        .ic_fill(ic_fill), .dc_fill(dc_fill)
    );

    mem_arbiter #(.MEM_LATENCY(2), .MEM_LINES(1024)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .ic_req(f_ic_req), .dc_req(f_dc_req),
        .ic_mem_instr(f_ic_op), .dc_mem_instr(f_dc_op),
        .ic_addr(f_ic_addr), .dc_addr(f_dc_addr),
        .ic_wdata(f_ic_wdata), .dc_wdata(f_dc_wdata),
        .ic_grant(f_ic_grant), .dc_grant(f_dc_grant),
        .ic_resp(f_ic_resp), .dc_resp(f_dc_resp),
        .ic_fill(f_ic_fill), .dc_fill(f_dc_fill)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // who: 0 = main icache, 1 = main dcache, 2 = fast dcache
    task automatic drive(input int unsigned who, input logic req, input logic op,
                         input logic [TAG_BITS-1:0] a, input logic [127:0] wd);
        case (who)
            0:       begin ic_req = req;   ic_op = op;   ic_addr = a;   ic_wdata = wd;   end
            1:       begin dc_req = req;   dc_op = op;   dc_addr = a;   dc_wdata = wd;   end
            default: begin f_dc_req = req; f_dc_op = op; f_dc_addr = a; f_dc_wdata = wd; end
        endcase
    endtask

    function automatic logic [129:0] mine(input int unsigned who);
        case (who)
            0:       return {ic_grant, ic_resp, ic_fill};
            1:       return {dc_grant, dc_resp, dc_fill};
            default: return {f_dc_grant, f_dc_resp, f_dc_fill};
        endcase
    endfunction

    function automatic logic [129:0] other(input int unsigned who);
        case (who)
            0:       return {dc_grant, dc_resp, dc_fill};
            1:       return {ic_grant, ic_resp, ic_fill};
            default: return {f_ic_grant, f_ic_resp, f_ic_fill};
        endcase
    endfunction

    // One full transaction; after the grant the request inputs are scrambled to prove they are latched.
    task automatic xact(input int unsigned who, input logic op, input logic [TAG_BITS-1:0] a,
                        input logic [127:0] wd, input logic [127:0] exp,
                        input logic [TAG_BITS-1:0] a_after);
        int unsigned lat = (who == 2) ? 2 : 5;
        logic [129:0] m, o;
        drive(who, 1'b1, op, a, wd);
        step;
        m = mine(who); o = other(who);
        chk("grant", 128'(m[129]), 128'(1));
        chk("other_grant", 128'(o[129]), 128'(0));
        drive(who, 1'b0, ~op, a_after, ~wd);
        for (int i = 1; i < int'(lat); i++) begin
            step;
            m = mine(who);
            chk("early_resp", 128'(m[128]), 128'(0));
        end
        step;
        m = mine(who); o = other(who);
        chk("resp", 128'(m[128]), 128'(1));
        chk("fill", m[127:0], exp);
        chk("other_resp", 128'(o[128]), 128'(0));
        chk("other_fill", o[127:0], 128'(0));
        step;
        m = mine(who);
        chk("resp_after", 128'(m[128]), 128'(0));
        chk("fill_after", m[127:0], 128'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        ic_req = 0; dc_req = 0; ic_op = 0; dc_op = 0;
        ic_addr = '0; dc_addr = '0; ic_wdata = '0; dc_wdata = '0;
        f_ic_req = 0; f_dc_req = 0; f_ic_op = 0; f_dc_op = 0;
        f_ic_addr = '0; f_dc_addr = '0; f_ic_wdata = '0; f_dc_wdata = '0;
        step; step; step;
        chk("rst_ic_grant", 128'(ic_grant), 128'(0));
        chk("rst_dc_grant", 128'(dc_grant), 128'(0));
        chk("rst_ic_resp", 128'(ic_resp), 128'(0));
        chk("rst_dc_resp", 128'(dc_resp), 128'(0));
        chk("rst_ic_fill", ic_fill, 128'(0));
        chk("rst_dc_fill", dc_fill, 128'(0));
        rst_n = 1'b1;
        step;

        // preload 0x10 with A, then single load
        xact(1, STORE, 28'h10, PAT_A, PAT_A, 28'h10);
        xact(1, LOAD,  28'h10, '0,    PAT_A, 28'h11);

        // store then load through both ports
        xact(0, STORE, 28'h3, PAT_B, PAT_B, 28'h3);
        xact(0, LOAD,  28'h3, '0,    PAT_B, 28'h4);
        xact(1, LOAD,  28'h3, '0,    PAT_B, 28'h4);

        // alias wrap-around
        xact(0, STORE, 28'h005, PAT_C, PAT_C, 28'h005);
        xact(1, LOAD,  28'h405, '0,    PAT_C, 28'h006);

        // reset two cycles after grant aborts the store of D
        xact(1, STORE, 28'h7, PAT_E, PAT_E, 28'h7);
        drive(1, 1'b1, STORE, 28'h7, PAT_D);
        step;
        chk("abort_grant", 128'(dc_grant), 128'(1));
        drive(1, 1'b0, STORE, 28'h7, PAT_D);
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_resp", 128'(dc_resp), 128'(0));
            chk("abort_no_fill", dc_fill, 128'(0));
            step;
        end
        xact(1, LOAD, 28'h7, '0, PAT_E, 28'h8);

        // minimum latency instance, address changed after grant
        xact(2, STORE, 28'h20, PAT_F, PAT_F, 28'h20);
        xact(2, LOAD,  28'h20, '0,    PAT_F, 28'h21);

        // tie from reset release: ic, dc, ic, dc every 7 cycles
        rst_n = 1'b0;
        step; step;
        rst_n = 1'b1;
        ic_req = 1; dc_req = 1; ic_op = LOAD; dc_op = LOAD;
        ic_addr = 28'h10; dc_addr = 28'h3;
        for (int c = 1; c <= 27; c++) begin
            step;
            chk("tie_grants", 128'({ic_grant, dc_grant}),
                128'({(c == 1 || c == 15), (c == 8 || c == 22)}));
            chk("tie_resps", 128'({ic_resp, dc_resp}),
                128'({(c == 6 || c == 20), (c == 13 || c == 27)}));
            chk("tie_ic_fill", ic_fill, (c == 6 || c == 20) ? PAT_A : 128'(0));
            chk("tie_dc_fill", dc_fill, (c == 13 || c == 27) ? PAT_B : 128'(0));
            if (c == 22) begin
                ic_req = 0; dc_req = 0;
            end
        end
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 5: cycles from the grant pulse to the response pulse; legal range 2..15.
REQ-002 SHALL have parameter MEM_LINES, default 1024: number of cache lines in backing store; power of two.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port ic_req / dc_req, input, 1 each: instruction/data cache request.
REQ-006 SHALL have port ic_mem_instr / dc_mem_instr, input, 1 each: operation select, 0 = store line, 1 = load line.
REQ-007 SHALL have port ic_addr / dc_addr, input, TAG_BITS each: line address.
REQ-008 SHALL have port ic_wdata / dc_wdata, input, CACHE_LINE_LEN each: store line data.
REQ-009 SHALL have port ic_grant / dc_grant, output, 1 each: request accepted, one-cycle pulse.
REQ-010 SHALL have port ic_resp / dc_resp, output, 1 each: access complete, one-cycle pulse.
REQ-011 SHALL have port ic_fill / dc_fill, output, CACHE_LINE_LEN each: line data, valid while the matching resp is high.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 SHALL, in IDLE at a rising edge with any req high, latch the winner's op, addr and wdata, load the counter with MEM_LATENCY-1 and enter BUSY.
REQ-014 SHALL arbitrate round-robin: when both reqs are high, the port not granted last wins; a single req always wins.
REQ-015 SHALL assert the winner's grant, registered, for exactly the first BUSY cycle G.
REQ-016 SHALL decrement the counter in each BUSY cycle and enter RESP when it reaches 0, so the winner's resp is high in cycle G+MEM_LATENCY only.
REQ-017 SHALL drive fill with the addressed line on a load; on a store it SHALL echo the stored line.
REQ-018 SHALL write the store line into backing store at the end of the RESP cycle; a subsequent load of that line returns the new data.
REQ-019 SHALL return to IDLE after RESP; reqs present during BUSY or RESP are not sampled, so the earliest next grant is G+MEM_LATENCY+2.
REQ-020 SHALL ignore changes to the requester's addr, wdata or op after the grant.
REQ-021 SHALL index backing store with addr[$clog2(MEM_LINES)-1:0] and ignore the upper bits (aliasing wrap-around).
REQ-022 SHALL drive a fill of all zeros whenever its resp is low.
REQ-023 SHALL never assert both grants, or both resps, in the same cycle.

Reset
REQ-024 SHALL, with rst_n low at a rising edge, enter IDLE and drive all grants, resps and fills to 0.
REQ-025 SHALL reset the round-robin pointer so that icache wins the first tie.
REQ-026 SHALL, on reset mid-operation (BUSY or RESP), abort with no store write and no resp pulse.
REQ-027 SHALL leave backing store contents unchanged by reset.

Structure
REQ-028 SHALL take CACHE_LINE_LEN, ADDRESS_BITS, TAG_BITS and a mem_op_e enum (STORE = 0, LOAD = 1) from brisc_pkg.
REQ-029 SHALL keep the FSM state enum local to the module.
REQ-030 SHALL use one sub-module, main_memory: MEM_LINES x CACHE_LINE_LEN storage with a synchronous write port and a combinational read port; initialised from file parameter MEM_INIT_FILE, default "" (no init).

Verification
REQ-031 SHALL cover a single load: backing store line 0x10 preloaded with pattern A; dc_req with dc_mem_instr = 1, dc_addr = 0x10 at cycle 0 -> dc_grant in cycle 1, dc_resp with dc_fill = A in cycle 6, ic outputs stay 0.
REQ-032 SHALL cover store then load: ic stores pattern B at line 0x3; after its resp, ic loads 0x3 -> fill = B; a dc load of 0x3 also returns B.
REQ-033 SHALL cover a tie: ic_req and dc_req held high from reset release -> grant order ic, dc, ic, dc, with grant-to-grant spacing of MEM_LATENCY+2 cycles.
REQ-034 SHALL cover address wrap: store pattern C at line 0x005, then load line 0x405 with MEM_LINES = 1024 -> fill = C.
REQ-035 SHALL cover reset mid-operation: dc store pattern D to line 0x7 with rst_n low two cycles after the grant -> no dc_resp; a later load of 0x7 returns the old contents.
REQ-036 SHALL cover minimum latency: MEM_LATENCY = 2, load -> resp exactly 2 cycles after the grant; addr changed after the grant does not affect fill.
